// File: rtl/clk_share_arb.sv
// Round-robin grant controller for one shared clocked resource.
// Registered one-hot grant, one dead cycle between owners, hold-limit revoke.
module clk_share_arb #(
  parameter int N_REQ    = 4,
  parameter int HOLD_MAX = 8,
  parameter int IW       = $clog2(N_REQ),
  parameter int CW       = $clog2(HOLD_MAX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_done,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_gnt_idx,
  output logic             o_busy,
  output logic             o_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_e;

  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             tmo_q, tmo_d;

  logic             win_vld;
  logic [IW-1:0]    win_idx;
  logic [N_REQ-1:0] win_oh;
  logic             own_req;
  logic             own_done;
  logic             hold_end;

  // Search upward from the slot after the last owner, wrapping around.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      int j;
      j = (int'(ptr_q) + k) % N_REQ;
      if (!win_vld && i_req[j]) begin
        win_vld   = 1'b1;
        win_idx   = IW'(j);
        win_oh    = '0;
        win_oh[j] = 1'b1;
      end
    end
  end

  assign own_req  = i_req[idx_q];
  assign own_done = i_done[idx_q];
  assign hold_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE, GAP: begin
        if (win_vld) begin
          state_d = GRANT;
          gnt_d   = win_oh;
          idx_d   = win_idx;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      GRANT: begin
        cnt_d = hold_end ? cnt_q : cnt_q + 1'b1;
        if (own_done || !own_req || hold_end) begin
          state_d = GAP;
          gnt_d   = '0;
          ptr_d   = idx_q;
          // done or withdrawal wins over the hold limit
          tmo_d   = own_req && !own_done;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IW'(N_REQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign o_gnt     = gnt_q;
  assign o_gnt_idx = idx_q;
  assign o_busy    = busy_q;
  assign o_timeout = tmo_q;

endmodule

// File: doc/clk_share_arb.md
# clk_share_arb

Round-robin grant controller that shares one clocked resource among `N_REQ` requesters. It is modelled on a 4-lane clock bundle where each lane drives a registered state machine. It sits between the per-lane request logic and the shared resource, issuing a registered one-hot grant. Each grant is held until the owner finishes, withdraws, or exceeds a hold limit. It exercises clock-vector fan-out, FSMs driven from concatenated or vector signals, and async-reset scheduling in simulation.

## Interface

Parameters:

- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `HOLD_MAX`, default 8: maximum number of cycles a grant may be held; legal range 2..255.
- `IW`, default `$clog2(N_REQ)`: width of the grant index.
- `CW`, default `$clog2(HOLD_MAX)`: width of the hold counter.

Ports:

- `clk` input 1: single clock; all state is updated on `posedge clk`.
- `rst_n` input 1: reset, asynchronous and active-low.
- `i_req` input N_REQ: per-requester request level.
- `i_done` input N_REQ: per-requester completion strobe; only the bit at the current grant index is honoured.
- `o_gnt` output N_REQ: registered grant, one-hot or zero.
- `o_gnt_idx` output IW: index of the current or last grant.
- `o_busy` output 1: high when the state is not IDLE.
- `o_timeout` output 1: one-cycle pulse on a forced revoke.

## Operation

- States: IDLE (2'b00), GRANT (2'b01), GAP (2'b10). Encoding 2'b11 is illegal and recovers to IDLE.
- Internal registers:
  - `ptr` (IW bits): index of the last completed grant.
  - `cnt` (CW bits): hold counter.
- Arbitration:
  - Search `i_req` starting at `(ptr+1) mod N_REQ` and wrapping upward.
  - The first set bit wins.
  - The search is purely combinational; its result is registered into `o_gnt` and `o_gnt_idx`.
- IDLE:
  - If any `i_req` bit is set, go to GRANT with the winner; `cnt` <= 0.
  - Otherwise stay in IDLE.
- GRANT:
  - `o_gnt` holds `1 << idx`.
  - `cnt` increments every cycle and saturates at `HOLD_MAX-1`.
  - Exit to GAP when `i_done[idx]` = 1, or `i_req[idx]` = 0, or `cnt == HOLD_MAX-1`.
  - Only the timeout exit sets `o_timeout` = 1, for the first GAP cycle.
- GAP:
  - `o_gnt` = 0 for exactly one cycle.
  - `ptr` <= `idx`, latched on entry.
  - Then go to GRANT if any `i_req` bit is set, arbitrating from the new `ptr`; otherwise go to IDLE.
- Priority on simultaneous events in GRANT:
  - `i_done` or request withdrawal beats timeout; no pulse is issued.
  - Requests from other lanes never pre-empt the current grant.
- `o_gnt_idx` retains the last granted index while in GAP and IDLE.
- `o_busy` is registered: 1 in GRANT and GAP, 0 in IDLE.
- `i_done` bits at non-granted indices are ignored in every state.

## Timing

- Reset values: `o_gnt` = 0, `o_gnt_idx` = 0, `o_busy` = 0, `o_timeout` = 0, `cnt` = 0, state = IDLE.
- Reset value of `ptr` is `N_REQ-1`, so the first search starts at index 0.
- Assertion of `rst_n` clears all outputs immediately, without waiting for a clock edge. This applies even mid-grant.
- Deassertion of `rst_n` is synchronous to `clk` at the system level; no reset synchronizer is inside this block.
- Request-to-grant latency: a request sampled at edge N gives `o_gnt` valid after edge N.
- Hand-off between owners: done sampled at edge N gives GAP after edge N. The next `o_gnt` is valid after edge N+1, so there is exactly one dead cycle.
- Maximum grant length is `HOLD_MAX` cycles of `o_gnt` high. The timeout pulse coincides with the first GAP cycle.
- With all requesters continuously active and each holding a grant for G cycles, the rotation period is `N_REQ*(G+1)` cycles.

## Test plan

- Reset, then `i_req` = 4'b0100 → after one edge: `o_gnt` = 4'b0100, `o_gnt_idx` = 2, `o_busy` = 1.
- `i_req` = 4'b1111 held; `i_done` asserted for the current owner on each grant's 2nd cycle → grant order 0,1,2,3,0, with one `o_gnt` = 0 cycle between owners.
- `HOLD_MAX` = 8, `i_req` = 4'b0001 held, no done → `o_gnt` = 4'b0001 for 8 cycles, then GAP with `o_timeout` = 1 for 1 cycle, then re-grant of 0.
- `i_done[idx]` asserted in the same cycle that `cnt` reaches `HOLD_MAX-1` → GAP with `o_timeout` = 0.
- Owner drops `i_req` mid-grant while lane 3 is requesting → GAP next cycle, then `o_gnt` = 4'b1000.
- `rst_n` pulled low mid-grant at lane 2 → `o_gnt` = 0 without a clock edge; after release with `i_req` = 4'b0110 → first grant goes to lane 1.
